// File: rtl/egress_rr_scheduler.sv
// Round-robin drain of the four PCIE output FIFOs (lanes 4..7) onto one
// valid/ready egress stream, with saturating per-lane delivered-word counters.
module egress_rr_scheduler #(
    parameter int DATA_W = 12,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic [3:0]        empty_in,
    input  logic [DATA_W-1:0] data_in4,
    input  logic [DATA_W-1:0] data_in5,
    input  logic [DATA_W-1:0] data_in6,
    input  logic [DATA_W-1:0] data_in7,
    input  logic              out_ready,
    input  logic              req,
    input  logic [2:0]        idx,
    output logic [3:0]        pop,
    output logic              valid_out,
    output logic [DATA_W-1:0] data_out,
    output logic [2:0]        lane_out,
    output logic [CNT_W-1:0]  cnt_out,
    output logic              cnt_valid
);

    // Lanes are held internally as 0..3 (lane 4..7).
    logic [1:0]        last_grant_q, last_grant_d;
    logic              cap_valid_q;
    logic [1:0]        cap_lane_q;
    logic [DATA_W-1:0] cap_data;
    logic [DATA_W-1:0] buf_data_q [2];
    logic [1:0]        buf_lane_q [2];
    logic              wr_ptr_q, rd_ptr_q;
    logic [1:0]        count_q, count_d;
    logic [CNT_W-1:0]  cnt_q [4];
    logic [CNT_W-1:0]  cnt_out_q;
    logic              cnt_valid_q;

    logic       deq, enq, can_issue, found;
    logic [1:0] grant_lane, cand, head_lane;

    assign head_lane = buf_lane_q[rd_ptr_q];
    assign valid_out = (count_q != 2'd0);
    assign deq       = valid_out && out_ready;
    assign enq       = cap_valid_q;

    // Credit counts buffered words plus the one in flight, net of the word
    // leaving this cycle, so a departure frees its slot for a same-cycle pop.
    assign count_d   = count_q + {1'b0, enq} - {1'b0, deq};
    assign can_issue = reset && !init && (empty_in != 4'hF) && (count_d < 2'd2);

    always_comb begin
        grant_lane = last_grant_q;
        cand       = last_grant_q;
        found      = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_grant_q + 2'(k);
            if (!found && !empty_in[cand]) begin
                found      = 1'b1;
                grant_lane = cand;
            end
        end
    end

    assign last_grant_d = can_issue ? grant_lane : last_grant_q;
    assign pop          = can_issue ? (4'b0001 << grant_lane) : 4'b0000;

    always_comb begin
        case (cap_lane_q)
            2'd0:    cap_data = data_in4;
            2'd1:    cap_data = data_in5;
            2'd2:    cap_data = data_in6;
            default: cap_data = data_in7;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_q <= 2'd3;
            cap_valid_q  <= 1'b0;
            cap_lane_q   <= 2'd0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= 2'd0;
            cnt_out_q    <= '0;
            cnt_valid_q  <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            cap_valid_q  <= can_issue;
            cap_lane_q   <= grant_lane;
            count_q      <= count_d;
            if (enq) wr_ptr_q <= ~wr_ptr_q;
            if (deq) rd_ptr_q <= ~rd_ptr_q;
            cnt_valid_q <= req;
            if (req) cnt_out_q <= idx[2] ? cnt_q[idx[1:0]] : '0;
        end
    end

    // Storage only; occupancy and pointers carry the reset state.
    always_ff @(posedge clk) begin
        if (enq) begin
            buf_data_q[wr_ptr_q] <= cap_data;
            buf_lane_q[wr_ptr_q] <= cap_lane_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 4; k++) cnt_q[k] <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (init)
                    cnt_q[k] <= '0;
                else if (deq && head_lane == 2'(k) && cnt_q[k] != '1)
                    cnt_q[k] <= cnt_q[k] + CNT_W'(1);
            end
        end
    end

    assign data_out  = valid_out ? buf_data_q[rd_ptr_q] : '0;
    assign lane_out  = valid_out ? {1'b1, head_lane} : 3'd0;
    assign cnt_out   = cnt_out_q;
    assign cnt_valid = cnt_valid_q;

endmodule

// File: tb/tb_egress_rr_scheduler.sv
// Bench for egress_rr_scheduler: FIFO environment, queue-based scoreboard
// model checked every cycle, plus directed scenarios with literal expectations.
module tb_egress_rr_scheduler;

    logic        clk;
    logic        reset;
    logic        init;
    logic [3:0]  empty_in;
    logic [11:0] data_in [4];
    logic        out_ready;
    logic        req;
    logic [2:0]  idx;
    logic [3:0]  pop;
    logic        valid_out;
    logic [11:0] data_out;
    logic [2:0]  lane_out;
    logic [4:0]  cnt_out;
    logic        cnt_valid;

    egress_rr_scheduler #(.DATA_W(12), .CNT_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .init      (init),
        .empty_in  (empty_in),
        .data_in4  (data_in[0]),
        .data_in5  (data_in[1]),
        .data_in6  (data_in[2]),
        .data_in7  (data_in[3]),
        .out_ready (out_ready),
        .req       (req),
        .idx       (idx),
        .pop       (pop),
        .valid_out (valid_out),
        .data_out  (data_out),
        .lane_out  (lane_out),
        .cnt_out   (cnt_out),
        .cnt_valid (cnt_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // FIFO environment
    logic [11:0] fmem [4][128];
    int frd [4];
    int fwr [4];
    logic [3:0] pop_seen = 4'b0;

    // Scoreboard model
    typedef struct { int lane; int data; int t; } word_t;
    word_t sb [$];
    word_t w;
    int  cyc = 0;
    int  last_g = 3;
    int  mcnt [4] = '{0, 0, 0, 0};
    bit  cpend = 0;
    int  cexp = 0;
    bit  exp_valid, deq, found;
    logic [3:0] exp_pop;
    int  glane, l2;

    // Logs of what the DUT actually did
    int log_lane [$];
    int log_data [$];
    int log_t [$];
    int pop_lane [$];
    int pop_t [$];

    always @(negedge clk) begin
        pop_seen = pop;
        if (!reset) begin
            chk("rst_pop", pop, 0);
            chk("rst_valid", valid_out, 0);
            chk("rst_cnt_valid", cnt_valid, 0);
            sb.delete();
            last_g = 3;
            for (int k = 0; k < 4; k++) mcnt[k] = 0;
            cpend = 0;
        end else begin
            exp_valid = 1'b0;
            if (sb.size() > 0)
                if (sb[0].t + 2 <= cyc) exp_valid = 1'b1;
            chk("valid_out", valid_out, exp_valid);
            if (exp_valid) begin
                chk("data_out", data_out, sb[0].data);
                chk("lane_out", lane_out, sb[0].lane + 4);
            end
            deq = exp_valid && out_ready;

            exp_pop = 4'b0;
            glane = 0;
            if (!init && empty_in != 4'hF && (sb.size() - (deq ? 1 : 0)) < 2) begin
                found = 1'b0;
                for (int k = 1; k <= 4; k++) begin
                    l2 = (last_g + k) % 4;
                    if (!found && !empty_in[l2]) begin
                        found = 1'b1;
                        exp_pop[l2] = 1'b1;
                        glane = l2;
                    end
                end
            end
            chk("pop", pop, exp_pop);

            chk("cnt_valid", cnt_valid, cpend);
            if (cpend) chk("cnt_out", cnt_out, cexp);

            cpend = req;
            if (req) cexp = (idx >= 4) ? mcnt[idx - 4] : 0;
            if (deq) begin
                log_lane.push_back(lane_out);
                log_data.push_back(data_out);
                log_t.push_back(cyc);
                if (mcnt[sb[0].lane] < 31) mcnt[sb[0].lane]++;
                void'(sb.pop_front());
            end
            if (init)
                for (int k = 0; k < 4; k++) mcnt[k] = 0;
            if (pop != 4'b0)
                for (int k = 0; k < 4; k++)
                    if (pop[k]) begin pop_lane.push_back(k); pop_t.push_back(cyc); end
            if (exp_pop != 4'b0) begin
                w.lane = glane;
                w.data = fmem[glane][frd[glane]];
                w.t    = cyc;
                sb.push_back(w);
                last_g = glane;
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
        for (int l = 0; l < 4; l++)
            if (pop_seen[l] && frd[l] < fwr[l]) begin
                data_in[l] = fmem[l][frd[l]];
                frd[l]++;
                empty_in[l] = (frd[l] == fwr[l]);
            end
    endtask

    task automatic load(input int l, input int n, input int base);
        for (int k = 0; k < n; k++) begin
            fmem[l][fwr[l]] = 12'(base + k);
            fwr[l]++;
        end
        if (n > 0) empty_in[l] = 1'b0;
    endtask

    task automatic clear_logs();
        log_lane.delete(); log_data.delete(); log_t.delete();
        pop_lane.delete(); pop_t.delete();
    endtask

    task automatic wait_log(input int n, input int budget, input string name);
        int c = 0;
        while (log_lane.size() < n && c < budget) begin
            step();
            c++;
        end
        chk(name, log_lane.size(), n);
    endtask

    task automatic rd(input int i, input int exp, input string name);
        req = 1'b1;
        idx = 3'(i);
        step();
        chk({name, "_strobe"}, cnt_valid, 1);
        chk(name, cnt_out, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; init = 1'b0; empty_in = 4'hF; out_ready = 1'b1;
        req = 1'b0; idx = 3'd0;
        for (int l = 0; l < 4; l++) begin data_in[l] = 12'd0; frd[l] = 0; fwr[l] = 0; end

        // All lanes 3 words, round-robin from lane4 after reset
        for (int l = 0; l < 4; l++) load(l, 3, (l + 4) << 8);
        repeat (3) step();
        chk("init_pop", pop, 0);
        chk("init_valid", valid_out, 0);
        chk("init_lane", lane_out, 0);
        chk("init_cnt_out", cnt_out, 0);
        reset = 1'b1;
        wait_log(12, 40, "rr_delivered");
        for (int i = 0; i < 12; i++) begin
            if (i < log_lane.size()) begin
                chk("rr_lane", log_lane[i], (i % 4) + 4);
                chk("rr_data", log_data[i], (((i % 4) + 4) << 8) + (i / 4));
            end
        end
        chk("rr_pop_count", pop_t.size(), 12);
        if (pop_t.size() == 12) chk("rr_pop_span", pop_t[11] - pop_t[0], 11);
        if (log_t.size() == 12) chk("rr_valid_span", log_t[11] - log_t[0], 11);
        repeat (2) step();

        // Backpressure on lane5
        clear_logs();
        out_ready = 1'b0;
        load(1, 4, 12'h550);
        repeat (8) step();
        chk("bp_pop_count", pop_lane.size(), 2);
        chk("bp_valid", valid_out, 1);
        chk("bp_data_held", data_out, 12'h550);
        chk("bp_lane_held", lane_out, 5);
        out_ready = 1'b1;
        wait_log(4, 20, "bp_delivered");
        for (int i = 0; i < log_data.size(); i++) chk("bp_order", log_data[i], 12'h550 + i);
        if (log_t.size() == 4) chk("bp_rate", log_t[3] - log_t[0], 3);
        repeat (2) step();

        // Only lane6 non-empty
        clear_logs();
        load(2, 5, 12'h600);
        wait_log(5, 20, "l6_delivered");
        chk("l6_pop_count", pop_lane.size(), 5);
        for (int i = 0; i < pop_lane.size(); i++) chk("l6_pop_lane", pop_lane[i], 2);
        if (pop_t.size() == 5) chk("l6_pop_span", pop_t[4] - pop_t[0], 4);
        for (int i = 0; i < log_data.size(); i++) begin
            chk("l6_lane", log_lane[i], 6);
            chk("l6_data", log_data[i], 12'h600 + i);
        end
        repeat (2) step();

        // Counter saturation on lane7
        init = 1'b1;
        step();
        init = 1'b0;
        clear_logs();
        load(3, 33, 12'h700);
        wait_log(33, 60, "l7_delivered");
        repeat (2) step();
        rd(7, 31, "cnt7_sat");
        rd(4, 0, "cnt4_zero");
        rd(2, 0, "cnt_idx2_zero");
        req = 1'b0;
        step();
        chk("cnt_strobe_end", cnt_valid, 0);

        // init with a word in flight
        clear_logs();
        load(1, 1, 12'h5A0);
        step();
        init = 1'b1;
        load(2, 1, 12'h6A0);
        step();
        init = 1'b0;
        wait_log(2, 20, "init_delivered");
        if (log_lane.size() == 2) begin
            chk("init_inflight_lane", log_lane[0], 5);
            chk("init_inflight_data", log_data[0], 12'h5A0);
            chk("init_after_lane", log_lane[1], 6);
        end
        repeat (2) step();
        rd(4, 0, "clr_cnt4");
        rd(7, 0, "clr_cnt7");
        rd(6, 1, "clr_cnt6");
        rd(5, 1, "clr_cnt5");
        req = 1'b0;
        step();

        // Reset mid-traffic with two words buffered
        clear_logs();
        out_ready = 1'b0;
        for (int l = 0; l < 4; l++) load(l, 3, ((l + 4) << 8) + 12'h0C0);
        repeat (5) step();
        chk("pre_rst_valid", valid_out, 1);
        chk("pre_rst_cnt_out", cnt_out, 1);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("mid_rst_pop", pop, 0);
        chk("mid_rst_valid", valid_out, 0);
        chk("mid_rst_data", data_out, 0);
        chk("mid_rst_lane", lane_out, 0);
        chk("mid_rst_cnt_out", cnt_out, 0);
        chk("mid_rst_cnt_valid", cnt_valid, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        #2;
        chk("post_rst_grant", pop, 4'b0001);
        out_ready = 1'b1;
        wait_log(10, 40, "post_rst_delivered");
        if (log_lane.size() >= 2) begin
            chk("post_rst_first_lane", log_lane[0], 4);
            chk("post_rst_first_data", log_data[0], 12'h4C1);
            chk("post_rst_second_lane", log_lane[1], 5);
            chk("post_rst_second_data", log_data[1], 12'h5C0);
        end
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
